// File: rtl/calc_pkg.sv
// Shared constants and types for the keypad calculator controller.
// Key codes are row-major {row,col} as produced by the keypad scanner.
package calc_pkg;

   localparam int DIGITS   = 4;
   localparam int VAL_W    = 14;
   localparam int ACC_W    = 2 * VAL_W;
   localparam int BCD_W    = 4 * DIGITS;
   localparam int MAX_VAL  = 10 ** DIGITS - 1;
   localparam int ITERS    = VAL_W;

   localparam logic [VAL_W-1:0] ENTRY_LIM   = VAL_W'(10 ** (DIGITS - 1));
   localparam logic [BCD_W-1:0] ERR_DISPLAY = 16'hEEEE;

   localparam logic [3:0] KEY_1    = 4'h0;
   localparam logic [3:0] KEY_2    = 4'h1;
   localparam logic [3:0] KEY_3    = 4'h2;
   localparam logic [3:0] KEY_A    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_B    = 4'h7;
   localparam logic [3:0] KEY_7    = 4'h8;
   localparam logic [3:0] KEY_8    = 4'h9;
   localparam logic [3:0] KEY_9    = 4'hA;
   localparam logic [3:0] KEY_C    = 4'hB;
   localparam logic [3:0] KEY_ASS  = 4'hC;
   localparam logic [3:0] KEY_0    = 4'hD;
   localparam logic [3:0] KEY_HASH = 4'hE;
   localparam logic [3:0] KEY_D    = 4'hF;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ENTRY_LHS,
      OP_WAIT,
      ENTRY_RHS,
      SHOW_RESULT
   } phase_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CONV
   } state_t;

   // One double-dabble correction pass: +3 on every nibble >= 5.
   function automatic logic [BCD_W-1:0] bcd_adjust(
      input logic [BCD_W-1:0] v
   );
      logic [BCD_W-1:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         else
            r[4*i +: 4] = v[4*i +: 4];
      end
      return r;
   endfunction

endpackage

// File: rtl/calc_alu_iter.sv
// Arithmetic unit: single-cycle add/sub, 14-step shift-add multiply
// and 14-step restoring divide. The start edge performs the first step.
module calc_alu_iter
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start,
   input  op_t              op,
   input  logic [VAL_W-1:0] a,
   input  logic [VAL_W-1:0] b,
   output logic             done,
   output logic [ACC_W-1:0] result,
   output logic             err
);

   localparam logic [3:0] LAST = 4'(ITERS - 1);

   logic             run;
   logic [3:0]       cnt;
   op_t              op_q;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] mc;
   logic [VAL_W-1:0] mp;
   logic [VAL_W-1:0] dv;

   logic             is_mul;
   logic [ACC_W-1:0] s_acc;
   logic [ACC_W-1:0] s_mc;
   logic [VAL_W-1:0] s_mp;
   logic [VAL_W-1:0] s_dv;
   logic [VAL_W:0]   trial;
   logic [ACC_W-1:0] n_acc;
   logic [ACC_W-1:0] n_mc;
   logic [VAL_W-1:0] n_mp;
   logic [ACC_W-1:0] sum;

   assign sum = ACC_W'(a) + ACC_W'(b);

   // mp holds the multiplier (mul) or dividend/quotient (div)
   always_comb begin
      is_mul = start ? (op == MUL) : (op_q == MUL);
      s_acc  = start ? '0 : acc;
      s_mc   = start ? ACC_W'(a) : mc;
      s_mp   = start ? ((op == DIV) ? a : b) : mp;
      s_dv   = start ? b : dv;
      trial  = {s_acc[VAL_W-1:0], s_mp[VAL_W-1]};
      n_acc  = s_acc;
      n_mc   = s_mc;
      n_mp   = s_mp;
      if (is_mul) begin
         n_acc = s_acc + (s_mp[0] ? s_mc : '0);
         n_mc  = s_mc << 1;
         n_mp  = s_mp >> 1;
      end else if (trial >= {1'b0, s_dv}) begin
         n_acc = ACC_W'(trial - {1'b0, s_dv});
         n_mp  = {s_mp[VAL_W-2:0], 1'b1};
      end else begin
         n_acc = ACC_W'(trial);
         n_mp  = {s_mp[VAL_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         run    <= 1'b0;
         cnt    <= '0;
         op_q   <= ADD;
         acc    <= '0;
         mc     <= '0;
         mp     <= '0;
         dv     <= '0;
         done   <= 1'b0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            op_q <= op;
            unique case (op)
               ADD: begin
                  result <= sum;
                  err    <= sum > ACC_W'(MAX_VAL);
                  done   <= 1'b1;
               end
               SUB: begin
                  result <= ACC_W'(a) - ACC_W'(b);
                  err    <= a < b;
                  done   <= 1'b1;
               end
               default: begin
                  acc <= n_acc;
                  mc  <= n_mc;
                  mp  <= n_mp;
                  dv  <= b;
                  cnt <= 4'd1;
                  run <= 1'b1;
               end
            endcase
         end else if (run) begin
            acc <= n_acc;
            mc  <= n_mc;
            mp  <= n_mp;
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
               run    <= 1'b0;
               done   <= 1'b1;
               result <= is_mul ? n_acc : ACC_W'(n_mp);
               err    <= is_mul ? (n_acc > ACC_W'(MAX_VAL))
                                : (dv == '0);
            end
         end
      end
   end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: key edge detect, operand entry, ALU dispatch
// and double-dabble conversion of the displayed value.
module calc_controller
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             reset_in,
   input  logic [3:0]       key_code,
   input  logic             data_ready,
   output logic [BCD_W-1:0] data_out,
   output logic             busy,
   output logic             error
);

   localparam logic [3:0] LAST = 4'(ITERS - 1);

   state_t           state;
   phase_t           phase;
   phase_t           pend_phase;
   op_t              op;
   op_t              pend_op;
   logic [VAL_W-1:0] lhs;
   logic [VAL_W-1:0] rhs;
   logic             ready_q;
   logic [VAL_W-1:0] bin;
   logic [BCD_W-1:0] bcd;
   logic [3:0]       cnt;

   logic             is_digit;
   logic             is_op;
   logic             is_ce;
   logic             is_eq;
   logic [3:0]       digit;
   op_t              key_op;

   logic             ev;
   logic             go_conv;
   logic             go_exec;
   logic [VAL_W-1:0] n_lhs;
   logic [VAL_W-1:0] n_rhs;
   op_t              n_op;
   op_t              n_pend_op;
   phase_t           n_phase;
   phase_t           n_pend_phase;
   logic             n_err;
   logic [VAL_W-1:0] disp;

   logic                   alu_done;
   logic                   alu_err;
   logic [ACC_W-1:0]       alu_result;
   logic                   res_bad;
   logic [BCD_W+VAL_W-1:0] dd_next;

   assign ev      = data_ready && !ready_q && (state == IDLE);
   assign res_bad = alu_err || (|alu_result[ACC_W-1:VAL_W]);
   assign dd_next = {bcd_adjust(bcd), bin} << 1;

   always_comb begin
      is_digit = 1'b1;
      is_op    = 1'b0;
      is_ce    = 1'b0;
      is_eq    = 1'b0;
      digit    = 4'd0;
      key_op   = ADD;
      unique case (key_code)
         KEY_0:    digit = 4'd0;
         KEY_1:    digit = 4'd1;
         KEY_2:    digit = 4'd2;
         KEY_3:    digit = 4'd3;
         KEY_4:    digit = 4'd4;
         KEY_5:    digit = 4'd5;
         KEY_6:    digit = 4'd6;
         KEY_7:    digit = 4'd7;
         KEY_8:    digit = 4'd8;
         KEY_9:    digit = 4'd9;
         KEY_A:    begin is_digit = 1'b0; is_op = 1'b1; key_op = ADD; end
         KEY_B:    begin is_digit = 1'b0; is_op = 1'b1; key_op = SUB; end
         KEY_C:    begin is_digit = 1'b0; is_op = 1'b1; key_op = MUL; end
         KEY_D:    begin is_digit = 1'b0; is_op = 1'b1; key_op = DIV; end
         KEY_ASS:  begin is_digit = 1'b0; is_ce = 1'b1; end
         KEY_HASH: begin is_digit = 1'b0; is_eq = 1'b1; end
      endcase
   end

   // Next architectural state for an accepted key event in IDLE
   always_comb begin
      n_lhs        = lhs;
      n_rhs        = rhs;
      n_op         = op;
      n_phase      = phase;
      n_err        = error;
      n_pend_op    = op;
      n_pend_phase = phase;
      go_conv      = 1'b0;
      go_exec      = 1'b0;
      if (ev) begin
         unique case (1'b1)
            is_ce: begin
               go_conv = 1'b1;
               n_lhs   = '0;
               n_rhs   = '0;
               n_op    = ADD;
               n_phase = ENTRY_LHS;
               n_err   = 1'b0;
            end
            is_digit: begin
               go_conv = 1'b1;
               if (error) begin
                  n_err   = 1'b0;
                  n_lhs   = VAL_W'(digit);
                  n_rhs   = '0;
                  n_phase = ENTRY_LHS;
               end else begin
                  unique case (phase)
                     ENTRY_LHS:
                        if (lhs < ENTRY_LIM)
                           n_lhs = lhs * VAL_W'(10) + VAL_W'(digit);
                     SHOW_RESULT: begin
                        n_lhs   = VAL_W'(digit);
                        n_phase = ENTRY_LHS;
                     end
                     OP_WAIT: begin
                        n_rhs   = VAL_W'(digit);
                        n_phase = ENTRY_RHS;
                     end
                     ENTRY_RHS:
                        if (rhs < ENTRY_LIM)
                           n_rhs = rhs * VAL_W'(10) + VAL_W'(digit);
                  endcase
               end
            end
            default: begin
               if (!error) begin
                  if (phase == ENTRY_RHS) begin
                     go_exec      = 1'b1;
                     n_pend_op    = is_op ? key_op : op;
                     n_pend_phase = is_op ? OP_WAIT : SHOW_RESULT;
                  end else begin
                     go_conv = 1'b1;
                     if (is_op && !is_eq) begin
                        n_op    = key_op;
                        n_phase = OP_WAIT;
                     end
                  end
               end
            end
         endcase
      end
      disp = (n_phase == ENTRY_RHS) ? n_rhs : n_lhs;
   end

   calc_alu_iter u_alu (
      .clk      (clk),
      .reset_in (reset_in),
      .start    (go_exec),
      .op       (op),
      .a        (lhs),
      .b        (rhs),
      .done     (alu_done),
      .result   (alu_result),
      .err      (alu_err)
   );

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state      <= IDLE;
         phase      <= ENTRY_LHS;
         pend_phase <= ENTRY_LHS;
         op         <= ADD;
         pend_op    <= ADD;
         lhs        <= '0;
         rhs        <= '0;
         ready_q    <= 1'b0;
         bin        <= '0;
         bcd        <= '0;
         cnt        <= '0;
         data_out   <= '0;
         busy       <= 1'b0;
         error      <= 1'b0;
      end else begin
         ready_q <= data_ready;
         unique case (state)
            IDLE: begin
               if (go_exec) begin
                  state      <= EXEC;
                  busy       <= 1'b1;
                  pend_op    <= n_pend_op;
                  pend_phase <= n_pend_phase;
               end else if (go_conv) begin
                  lhs   <= n_lhs;
                  rhs   <= n_rhs;
                  op    <= n_op;
                  phase <= n_phase;
                  error <= n_err;
                  bin   <= disp;
                  bcd   <= '0;
                  cnt   <= '0;
                  state <= CONV;
                  busy  <= 1'b1;
               end
            end
            EXEC: begin
               if (alu_done) begin
                  if (res_bad) begin
                     data_out <= ERR_DISPLAY;
                     error    <= 1'b1;
                     lhs      <= '0;
                     rhs      <= '0;
                     phase    <= ENTRY_LHS;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     lhs   <= alu_result[VAL_W-1:0];
                     op    <= pend_op;
                     phase <= pend_phase;
                     bin   <= alu_result[VAL_W-1:0];
                     bcd   <= '0;
                     cnt   <= '0;
                     state <= CONV;
                  end
               end
            end
            CONV: begin
               bcd <= dd_next[BCD_W+VAL_W-1:VAL_W];
               bin <= dd_next[VAL_W-1:0];
               cnt <= cnt + 4'd1;
               if (cnt == LAST) begin
                  data_out <= dd_next[BCD_W+VAL_W-1:VAL_W];
                  state    <= IDLE;
                  busy     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: key sequences with hand-computed
// display values, busy lengths, edge detection and mid-operation reset.
module tb_calc_controller;

   localparam logic [3:0] K1 = 4'h0;
   localparam logic [3:0] K2 = 4'h1;
   localparam logic [3:0] K3 = 4'h2;
   localparam logic [3:0] KA = 4'h3;
   localparam logic [3:0] K4 = 4'h4;
   localparam logic [3:0] K5 = 4'h5;
   localparam logic [3:0] K6 = 4'h6;
   localparam logic [3:0] KB = 4'h7;
   localparam logic [3:0] K7 = 4'h8;
   localparam logic [3:0] K8 = 4'h9;
   localparam logic [3:0] K9 = 4'hA;
   localparam logic [3:0] KC = 4'hB;
   localparam logic [3:0] KS = 4'hC;
   localparam logic [3:0] K0 = 4'hD;
   localparam logic [3:0] KH = 4'hE;
   localparam logic [3:0] KD = 4'hF;

   logic        clk = 1'b0;
   logic        reset_in;
   logic [3:0]  key_code;
   logic        data_ready;
   logic [15:0] data_out;
   logic        busy;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   calc_controller dut (
      .clk        (clk),
      .reset_in   (reset_in),
      .key_code   (key_code),
      .data_ready (data_ready),
      .data_out   (data_out),
      .busy       (busy),
      .error      (error)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic press(input logic [3:0] k, output int cyc);
      @(negedge clk);
      key_code   = k;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      wait_idle(cyc);
   endtask

   task automatic key(input string tag, input logic [3:0] k,
                      input logic [15:0] exp_do, input int exp_busy,
                      input logic exp_err);
      int cyc;
      press(k, cyc);
      check({tag, ".busy"}, cyc, exp_busy);
      check({tag, ".data"}, data_out, exp_do);
      check({tag, ".err"}, error, exp_err);
   endtask

   initial begin
      int nev;
      int cyc;
      logic prev;
      reset_in   = 1'b1;
      data_ready = 1'b0;
      key_code   = 4'h0;
      repeat (3) @(negedge clk);
      check("rst.data", data_out, 16'h0000);
      check("rst.busy", busy, 1'b0);
      check("rst.err", error, 1'b0);
      reset_in = 1'b0;

      key("d1", K1, 16'h0001, 14, 0);
      key("d2", K2, 16'h0012, 14, 0);
      key("d3", K3, 16'h0123, 14, 0);

      // 12 + 30 = 42, then a digit starts a fresh lhs
      key("ce1", KS, 16'h0000, 14, 0);
      key("a1", K1, 16'h0001, 14, 0);
      key("a2", K2, 16'h0012, 14, 0);
      key("aop", KA, 16'h0012, 14, 0);
      key("a3", K3, 16'h0003, 14, 0);
      key("a0", K0, 16'h0030, 14, 0);
      key("aeq", KH, 16'h0042, 15, 0);
      key("a5", K5, 16'h0005, 14, 0);

      // fifth digit ignored; 9999*2 overflows
      key("ce2", KS, 16'h0000, 14, 0);
      key("n1", K9, 16'h0009, 14, 0);
      key("n2", K9, 16'h0099, 14, 0);
      key("n3", K9, 16'h0999, 14, 0);
      key("n4", K9, 16'h9999, 14, 0);
      key("n5", K9, 16'h9999, 14, 0);
      key("nop", KC, 16'h9999, 14, 0);
      key("n2b", K2, 16'h0002, 14, 0);
      key("neq", KH, 16'hEEEE, 14, 1);
      key("nign", KA, 16'hEEEE, 0, 1);

      // divide by zero, then CE
      key("z7", K7, 16'h0007, 14, 0);
      key("zop", KD, 16'h0007, 14, 0);
      key("z0", K0, 16'h0000, 14, 0);
      key("zeq", KH, 16'hEEEE, 14, 1);
      key("zce", KS, 16'h0000, 14, 0);

      // negative subtraction
      key("s3", K3, 16'h0003, 14, 0);
      key("sop", KB, 16'h0003, 14, 0);
      key("s5", K5, 16'h0005, 14, 0);
      key("seq", KH, 16'hEEEE, 1, 1);
      key("sce", KS, 16'h0000, 14, 0);

      // (8 - 3) * 4 = 20, then 20 / 3 = 6
      key("c8", K8, 16'h0008, 14, 0);
      key("cb", KB, 16'h0008, 14, 0);
      key("c3", K3, 16'h0003, 14, 0);
      key("cc", KC, 16'h0005, 15, 0);
      key("c4", K4, 16'h0004, 14, 0);
      key("ceq", KH, 16'h0020, 28, 0);
      key("cd", KD, 16'h0020, 14, 0);
      key("c3b", K3, 16'h0003, 14, 0);
      key("cdv", KH, 16'h0006, 28, 0);

      // held data_ready yields a single event
      @(negedge clk);
      key_code   = K3;
      data_ready = 1'b1;
      nev        = 0;
      prev       = busy;
      repeat (100) begin
         @(negedge clk);
         if (busy && !prev) nev++;
         prev = busy;
      end
      data_ready = 1'b0;
      wait_idle(cyc);
      check("hold.events", nev, 1);
      check("hold.data", data_out, 16'h0003);

      // pulse while busy is dropped
      @(negedge clk);
      key_code   = K2;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      repeat (3) @(negedge clk);
      key_code   = K1;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      wait_idle(cyc);
      check("pulse.data", data_out, 16'h0032);
      repeat (3) @(negedge clk);
      check("pulse.idle", busy, 1'b0);

      // reset in the 9th multiply cycle of 50 * 6
      key("r_ce", KS, 16'h0000, 14, 0);
      key("r5", K5, 16'h0005, 14, 0);
      key("r0", K0, 16'h0050, 14, 0);
      key("rop", KC, 16'h0050, 14, 0);
      key("r6", K6, 16'h0006, 14, 0);
      @(negedge clk);
      key_code   = KH;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      repeat (8) @(negedge clk);
      check("rmid.busy", busy, 1'b1);
      reset_in = 1'b1;
      @(negedge clk);
      check("rmid.after_busy", busy, 1'b0);
      check("rmid.after_data", data_out, 16'h0000);
      check("rmid.after_err", error, 1'b0);
      reset_in = 1'b0;
      key("post", K7, 16'h0007, 14, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
